// File: rtl/voice_mixer_pkg.sv
// Shared constants for the voice mixer: voice count, envelope, tick and sigma-delta sizing.
// Envelope ramps are enabled by defining MIXER_ENV_EN; otherwise levels switch hard between 0 and max.
package voice_mixer_pkg;

    localparam int OSC_VOICES         = 7;
    localparam int MIXER_ENV_BW       = 6;
    localparam int MIXER_SAMPLE_DIV   = 256;
    localparam int MIXER_IDLE_TICKS   = 64;
    localparam int MIXER_ATTACK_STEP  = 4;
    localparam int MIXER_RELEASE_STEP = 1;

    localparam int MIXER_ENV_MAX = (1 << MIXER_ENV_BW) - 1;
    localparam int MIXER_FS      = OSC_VOICES * MIXER_ENV_MAX;
    localparam int SUM_BW        = $clog2(MIXER_FS + 1);
    localparam int IDLE_BW       = $clog2(MIXER_IDLE_TICKS + 1);
    localparam int DIV_BW        = $clog2(MIXER_SAMPLE_DIV);

endpackage

// File: rtl/voice_mixer_env.sv
// Per-voice activity detector and envelope: edge flag, saturating idle counter, clamped level.
// With MIXER_ENV_EN defined the level ramps by attack/release steps, else it jumps 0 <-> max.
module voice_env
    import voice_mixer_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    nrst_i,
    input  logic                    tick,
    input  logic                    wave,
    output logic [MIXER_ENV_BW-1:0] level
);

    localparam logic [IDLE_BW-1:0]      IDLE_LIMIT = IDLE_BW'(MIXER_IDLE_TICKS);
    localparam logic [MIXER_ENV_BW-1:0] LEVEL_MAX  = '1;

    logic                    waveQ;
    logic                    edgeSeen;
    logic                    waveEdge;
    logic                    active;
    logic [IDLE_BW-1:0]      idle;
    logic [MIXER_ENV_BW-1:0] levelNext;

    assign waveEdge = wave ^ waveQ;
    // Uses the idle value before this tick's update, so the envelope trails activity by one tick.
    assign active   = idle < IDLE_LIMIT;

`ifdef MIXER_ENV_EN
    localparam logic [MIXER_ENV_BW:0]   ATTACK_L  = (MIXER_ENV_BW + 1)'(MIXER_ATTACK_STEP);
    localparam logic [MIXER_ENV_BW-1:0] RELEASE_L = MIXER_ENV_BW'(MIXER_RELEASE_STEP);

    logic [MIXER_ENV_BW:0] attackSum;

    always_comb begin
        attackSum = {1'b0, level} + ATTACK_L;
        levelNext = level;
        if (active) begin
            levelNext = (attackSum > {1'b0, LEVEL_MAX}) ? LEVEL_MAX : attackSum[MIXER_ENV_BW-1:0];
        end else begin
            levelNext = (level >= RELEASE_L) ? level - RELEASE_L : '0;
        end
    end
`else
    always_comb begin
        levelNext = active ? LEVEL_MAX : '0;
    end
`endif

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            waveQ    <= 1'b0;
            edgeSeen <= 1'b0;
            idle     <= IDLE_LIMIT;
            level    <= '0;
        end else begin
            waveQ <= wave;
            if (tick) begin
                edgeSeen <= 1'b0;
                level    <= levelNext;
                if (edgeSeen || waveEdge) begin
                    idle <= '0;
                end else if (idle < IDLE_LIMIT) begin
                    idle <= idle + 1'b1;
                end
            end else if (waveEdge) begin
                edgeSeen <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/voice_mixer.sv
// Voice mixer top: envelope tick divider, per-voice envelopes, gated voice sum and 1-bit sigma-delta output.
// Optional ramped envelopes via MIXER_ENV_EN (see voice_env).
module voice_mixer
    import voice_mixer_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  nrst_i,
    input  logic [OSC_VOICES-1:0] wave_i,
    output logic                  audio_o,
    output logic [SUM_BW-1:0]     mix_o,
    output logic                  busy_o
);

    localparam logic [DIV_BW-1:0] DIV_LAST = DIV_BW'(MIXER_SAMPLE_DIV - 1);
    localparam logic [SUM_BW:0]   FS_L     = (SUM_BW + 1)'(MIXER_FS);

    logic [DIV_BW-1:0]       div;
    logic                    tick;
    logic [MIXER_ENV_BW-1:0] levels [OSC_VOICES];
    logic [SUM_BW-1:0]       mixSum;
    logic                    anyLevel;
    logic [SUM_BW:0]         acc;
    logic [SUM_BW:0]         sdSum;

    assign tick = (div == DIV_LAST);

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            div <= '0;
        end else begin
            div <= tick ? '0 : div + 1'b1;
        end
    end

    for (genvar v = 0; v < OSC_VOICES; v++) begin : gVoice
        voice_env uEnv (
            .clk_i  (clk_i),
            .nrst_i (nrst_i),
            .tick   (tick),
            .wave   (wave_i[v]),
            .level  (levels[v])
        );
    end

    // A voice only contributes while its square wave is high.
    always_comb begin
        mixSum   = '0;
        anyLevel = 1'b0;
        for (int v = 0; v < OSC_VOICES; v++) begin
            if (wave_i[v]) begin
                mixSum = mixSum + SUM_BW'(levels[v]);
            end
            anyLevel = anyLevel | (levels[v] != '0);
        end
    end

    // acc stays below FS, so acc + mix never exceeds 2*FS-1 and fits SUM_BW+1 bits.
    assign sdSum = acc + {1'b0, mix_o};

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            mix_o   <= '0;
            busy_o  <= 1'b0;
            acc     <= '0;
            audio_o <= 1'b0;
        end else begin
            mix_o  <= mixSum;
            busy_o <= anyLevel;
            if (sdSum >= FS_L) begin
                audio_o <= 1'b1;
                acc     <= sdSum - FS_L;
            end else begin
                audio_o <= 1'b0;
                acc     <= sdSum;
            end
        end
    end

endmodule

// File: doc/voice_mixer.md
Name: voice_mixer

Overview:
- Downstream of the synth oscillator stack: consumes the per-voice square waves (oscOut_o bus) and produces one 1-bit audio stream for a single output pin and RC filter.
- Per voice: activity detection from wave edges and a saturating attack/release envelope.
- Voice contributions are summed and the sum drives a first-order sigma-delta modulator running at clk rate.

Parameters:
- VOICES, 7, number of voice inputs; equals OSC_VOICES.
- ENV_BW, 6, envelope level width; ENV_MAX = 2^ENV_BW-1 = 63.
- SAMPLE_DIV, 256, clocks per envelope tick.
- IDLE_TICKS, 64, ticks without a wave edge before a voice is inactive.
- ATTACK_STEP, 4, level increment per tick while active.
- RELEASE_STEP, 1, level decrement per tick while inactive.

Ports:
- clk_i  in  1  system clock; single clock domain.
- nrst_i  in  1  reset, asynchronous, active-low.
- wave_i  in  VOICES  oscillator square waves, synchronous to clk_i.
- audio_o  out  1  sigma-delta bitstream.
- mix_o  out  SUM_BW  registered voice sum; SUM_BW = clog2(VOICES*ENV_MAX+1) = 9.
- busy_o  out  1  high while any envelope level is nonzero.

Behaviour:
- Reset state (asynchronous, immediate on nrst_i low):
  - div counter = 0, levels = 0, idle counters = IDLE_TICKS, edge flags = 0, wave history = 0.
  - acc = 0, audio_o = 0, mix_o = 0, busy_o = 0.
- Tick generator:
  - div counts 0..SAMPLE_DIV-1 and wraps.
  - tick is high in the cycle where div = SAMPLE_DIV-1.
- Edge detect: edge[i] = wave_i[i] XOR previous registered wave[i]. edgeSeen[i] is set on edge and cleared at tick.
- Idle counter update, at tick only:
  - if edgeSeen[i] or edge[i] in that same cycle: idle[i] <= 0. A simultaneous edge and tick counts as an edge.
  - else idle[i] <= min(idle[i]+1, IDLE_TICKS). Saturates, never wraps.
- active[i] = (idle[i] < IDLE_TICKS), using the pre-update value. Envelope therefore lags activity by one tick.
- Envelope update, at tick only:
  - active: level <= min(level+ATTACK_STEP, ENV_MAX).
  - inactive: level <= max(level-RELEASE_STEP, 0).
  - Clamped, never wraps.
- mix_o, registered every clock = sum over i of (wave_i[i] ? level[i] : 0). Latency 1 clock from wave_i and from level change.
- Sigma-delta, every clock. FS = VOICES*ENV_MAX = 441; acc width SUM_BW+1.
  - s = acc + mix_o.
  - If s >= FS: audio_o <= 1 and acc <= s-FS. Else audio_o <= 0 and acc <= s.
  - Constant mix m gives exactly m ones per FS clocks.
  - mix = 0 gives audio_o constant 0; mix = FS gives constant 1.
- busy_o: registered OR of (level[i] != 0). 1 clock after levels.
- Stuck-high wave (no edges): voice goes inactive after IDLE_TICKS and decays to 0. No DC remains.
- Reset mid-operation aborts everything. After release, the first tick occurs SAMPLE_DIV clocks later.

Optional Feature:
- Macro: MIXER_ENV_EN.
- Defined: attack/release ramps as specified above.
- Undefined:
  - ramp logic is removed.
  - at tick, level <= active ? ENV_MAX : 0.
  - ATTACK_STEP and RELEASE_STEP are ignored.
  - all other timing is unchanged.

Decomposition:
- global.v holds shared constants:
  - OSC_VOICES.
  - MIXER_ENV_BW, MIXER_SAMPLE_DIV, MIXER_IDLE_TICKS, MIXER_ATTACK_STEP, MIXER_RELEASE_STEP.
- Sub-module voice_env: edge detect, edgeSeen, idle counter and envelope for one voice. Inputs clk_i, nrst_i, tick, wave; output level.
  - Instantiated VOICES times in a generate loop.
- Tick divider, adder tree and sigma-delta stay in voice_mixer.

Test Plan:
1. Reset, all waves low, run 10 ticks -> audio_o, mix_o and busy_o stay 0. Assert nrst_i low mid-run -> outputs 0 the same clock.
2. Voice0 toggles every 100 clk (ENV_EN on) -> level 0,4,8..60,63 on successive ticks, saturating at tick 16. mix_o = 63 while wave high, 0 while low. audio_o gives 63 ones per 441 clks during high phases.
3. All 7 voices toggle in phase until saturated, then all high -> mix_o = 441 and audio_o constant 1. All low -> audio_o constant 0 after acc drains.
4. Voice0 at 63, then wave frozen high -> level holds for 64 ticks, then drops by 1 per tick, reaching 0 63 ticks later. busy_o falls 1 clk after that.
5. Edge exactly in the tick cycle of a voice with idle = 63 -> idle resets to 0 and the voice stays active (no release step).
6. MIXER_ENV_EN undefined, voice0 starts toggling -> level jumps 0->63 at the second tick after the first edge. After 64 idle ticks it drops 63->0 in a single tick.
